// File: rtl/processor_status_stack_if.sv
// rtl/processor_status_stack_if.sv - flag-write, snapshot-stack and status bundle for the status register
interface processor_status_stack_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] i_db;
    logic [WIDTH-1:0] i_db_we;
    logic [WIDTH-1:0] i_set;
    logic [WIDTH-1:0] i_clr;
    logic             i_acr;
    logic             i_acr_c;
    logic             i_avr;
    logic             i_avr_v;
    logic             i_dbz_z;
    logic             i_dbn_n;
    logic             i_push;
    logic             i_pop;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_p;
    logic [DW-1:0]    o_depth;
    logic             o_full;
    logic             o_empty;
    logic             o_ovf_err;
    logic             o_unf_err;

    modport master (
        output i_db, i_db_we, i_set, i_clr, i_acr, i_acr_c, i_avr, i_avr_v,
               i_dbz_z, i_dbn_n, i_push, i_pop, i_err_clr,
        input  o_p, o_depth, o_full, o_empty, o_ovf_err, o_unf_err
    );

    modport slave (
        input  i_db, i_db_we, i_set, i_clr, i_acr, i_acr_c, i_avr, i_avr_v,
               i_dbz_z, i_dbn_n, i_push, i_pop, i_err_clr,
        output o_p, o_depth, o_full, o_empty, o_ovf_err, o_unf_err
    );
endinterface

// File: rtl/processor_status_stack.sv
// rtl/processor_status_stack.sv - processor status flags with a falling-edge snapshot stack
module processor_status_stack #(
    parameter int               WIDTH          = 8,
    parameter int               STACK_DEPTH    = 4,
    parameter logic [WIDTH-1:0] CONST_ONE_MASK = WIDTH'(8'h20),
    parameter logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(8'h00),
    parameter int               C_BIT          = 0,
    parameter int               Z_BIT          = 1,
    parameter int               V_BIT          = 6,
    parameter int               N_BIT          = 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    processor_status_stack_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_out;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] flag_d;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] special_en;
    logic [WIDTH-1:0] special_val;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [DW-1:0]    wr_idx;
    logic             wr_en;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             unf_q;
    logic             pop_ok;
    logic             ovf_set;
    logic             unf_set;

    assign p_out = p_q | CONST_ONE_MASK;

    always_comb begin
        special_en               = '0;
        special_val              = '0;
        special_en[C_BIT]        = bus.i_acr_c;
        special_val[C_BIT]       = bus.i_acr;
        special_en[V_BIT]        = bus.i_avr_v;
        special_val[V_BIT]       = bus.i_avr;
        special_en[Z_BIT]        = bus.i_dbz_z;
        special_val[Z_BIT]       = (bus.i_db == '0);
        special_en[N_BIT]        = bus.i_dbn_n;
        special_val[N_BIT]       = bus.i_db[WIDTH-1];
    end

    always_comb begin
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_val = stack_mem[i];
        end
    end

    // Per-bit source priority below the pop restore: set, clear, special source, bus load.
    always_comb begin
        flag_d = p_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.i_set[k])           flag_d[k] = 1'b1;
            else if (bus.i_clr[k])      flag_d[k] = 1'b0;
            else if (special_en[k])     flag_d[k] = special_val[k];
            else if (bus.i_db_we[k])    flag_d[k] = bus.i_db[k];
        end
    end

    always_comb begin
        pop_ok  = bus.i_pop && !empty_q;
        p_d     = pop_ok ? top_val : flag_d;
        wr_en   = 1'b0;
        wr_idx  = depth_q;
        depth_d = depth_q;
        ovf_set = bus.i_push && full_q && !pop_ok;
        unf_set = bus.i_pop && empty_q;
        if (bus.i_push && pop_ok) begin
            // Swap: the old top is restored while the pre-edge word replaces it.
            wr_en  = 1'b1;
            wr_idx = depth_q - DW'(1);
        end else if (bus.i_push && !full_q) begin
            wr_en   = 1'b1;
            wr_idx  = depth_q;
            depth_d = depth_q + DW'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p_q     <= RESET_VALUE;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            depth_q <= depth_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == DW'(STACK_DEPTH));
            ovf_q   <= (ovf_q && !bus.i_err_clr) || ovf_set;
            unf_q   <= (unf_q && !bus.i_err_clr) || unf_set;
        end
    end

    always_ff @(negedge i_clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (wr_en && wr_idx == DW'(i)) stack_mem[i] <= p_out;
        end
    end

    assign bus.o_p       = p_out;
    assign bus.o_depth   = depth_q;
    assign bus.o_full    = full_q;
    assign bus.o_empty   = empty_q;
    assign bus.o_ovf_err = ovf_q;
    assign bus.o_unf_err = unf_q;
endmodule

// File: tb/tb_processor_status_stack.sv
// tb/tb_processor_status_stack.sv - directed and randomized checks against a queue-based status model
module tb_processor_status_stack;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    processor_status_stack_if #(.WIDTH(8), .STACK_DEPTH(4)) bus ();

    processor_status_stack dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Reference: flag word, a LIFO queue of snapshots, two sticky flags.
    logic [7:0] m_p   = 8'h20;
    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p   = 8'h20;
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            logic [7:0] pre;
            logic [7:0] nxt;
            logic [7:0] top;
            logic       had;
            logic       n_ovf;
            logic       n_unf;
            pre   = m_p;
            nxt   = m_p;
            had   = (m_q.size() > 0);
            top   = had ? m_q[m_q.size()-1] : 8'h00;
            n_ovf = 1'b0;
            n_unf = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (bus.i_set[k])                   nxt[k] = 1'b1;
                else if (bus.i_clr[k])              nxt[k] = 1'b0;
                else if (k == 0 && bus.i_acr_c)     nxt[k] = bus.i_acr;
                else if (k == 6 && bus.i_avr_v)     nxt[k] = bus.i_avr;
                else if (k == 1 && bus.i_dbz_z)     nxt[k] = (bus.i_db == 8'h00);
                else if (k == 7 && bus.i_dbn_n)     nxt[k] = bus.i_db[7];
                else if (bus.i_db_we[k])            nxt[k] = bus.i_db[k];
            end
            if (bus.i_pop && had) nxt = top;
            if (bus.i_push && bus.i_pop && had) begin
                m_q[m_q.size()-1] = pre;
            end else if (bus.i_push) begin
                if (m_q.size() < 4) m_q.push_back(pre);
                else n_ovf = 1'b1;
            end else if (bus.i_pop && had) begin
                void'(m_q.pop_back());
            end
            if (bus.i_pop && !had) n_unf = 1'b1;
            m_ovf = (m_ovf && !bus.i_err_clr) || n_ovf;
            m_unf = (m_unf && !bus.i_err_clr) || n_unf;
            m_p   = nxt | 8'h20;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (chk_en && rst_n) begin
            check("model_o_p",     32'(bus.o_p),       32'(m_p));
            check("model_depth",   32'(bus.o_depth),   32'(m_q.size()));
            check("model_full",    32'(bus.o_full),    32'(m_q.size() == 4));
            check("model_empty",   32'(bus.o_empty),   32'(m_q.size() == 0));
            check("model_ovf_err", 32'(bus.o_ovf_err), 32'(m_ovf));
            check("model_unf_err", 32'(bus.o_unf_err), 32'(m_unf));
        end
    end

    task automatic idle();
        bus.i_db = 8'h00; bus.i_db_we = 8'h00; bus.i_set = 8'h00; bus.i_clr = 8'h00;
        bus.i_acr = 1'b0; bus.i_acr_c = 1'b0; bus.i_avr = 1'b0; bus.i_avr_v = 1'b0;
        bus.i_dbz_z = 1'b0; bus.i_dbn_n = 1'b0; bus.i_push = 1'b0; bus.i_pop = 1'b0;
        bus.i_err_clr = 1'b0;
    endtask

    // Apply the current inputs across one falling edge, then return to idle inputs.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [7:0] v);
        bus.i_db = v; bus.i_db_we = 8'hFF;
        tick();
    endtask

    logic [7:0] pops [4];

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_p",   32'(bus.o_p),     32'h20);
        check("reset_depth", 32'(bus.o_depth), 32'd0);
        check("reset_empty", 32'(bus.o_empty), 32'd1);
        check("reset_full",  32'(bus.o_full),  32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check("release_o_p", 32'(bus.o_p), 32'h20);

        bus.i_db = 8'h00; bus.i_dbz_z = 1'b1; bus.i_acr = 1'b1; bus.i_acr_c = 1'b1;
        tick();
        check("zc_load", 32'(bus.o_p), 32'h23);
        bus.i_set = 8'h40; bus.i_clr = 8'h40;
        tick();
        check("set_wins", 32'(bus.o_p), 32'h63);

        load(8'hA1);
        bus.i_push = 1'b1;
        tick();
        load(8'h00);
        check("write_after_push", 32'(bus.o_p), 32'h20);
        bus.i_pop = 1'b1;
        tick();
        check("pop_restore", 32'(bus.o_p), 32'hA1);
        check("pop_depth",   32'(bus.o_depth), 32'd0);

        for (int i = 0; i < 5; i++) begin
            bus.i_push = 1'b1; bus.i_db = 8'(1 << i); bus.i_db_we = 8'hFF;
            tick();
            if (i == 3) check("full_after_4", 32'(bus.o_full), 32'd1);
        end
        check("ovf_depth", 32'(bus.o_depth), 32'd4);
        check("ovf_err",   32'(bus.o_ovf_err), 32'd1);
        check("ovf_write_applied", 32'(bus.o_p), 32'h30);
        for (int i = 0; i < 4; i++) begin
            bus.i_pop = 1'b1;
            tick();
            pops[i] = bus.o_p;
        end
        check("lifo_0", 32'(pops[0]), 32'h24);
        check("lifo_1", 32'(pops[1]), 32'h22);
        check("lifo_2", 32'(pops[2]), 32'h21);
        check("lifo_3", 32'(pops[3]), 32'hA1);
        bus.i_err_clr = 1'b1;
        tick();
        check("ovf_cleared", 32'(bus.o_ovf_err), 32'd0);

        bus.i_pop = 1'b1;
        tick();
        check("unf_set",     32'(bus.o_unf_err), 32'd1);
        check("unf_p_hold",  32'(bus.o_p),       32'hA1);
        bus.i_pop = 1'b1; bus.i_err_clr = 1'b1;
        tick();
        check("clr_vs_new_err", 32'(bus.o_unf_err), 32'd1);
        bus.i_err_clr = 1'b1;
        tick();
        check("unf_cleared", 32'(bus.o_unf_err), 32'd0);

        load(8'hE0);
        bus.i_push = 1'b1;
        tick();
        load(8'h21);
        bus.i_push = 1'b1; bus.i_pop = 1'b1;
        tick();
        check("swap_p",     32'(bus.o_p),     32'hE0);
        check("swap_depth", 32'(bus.o_depth), 32'd1);
        bus.i_pop = 1'b1;
        tick();
        check("swap_top", 32'(bus.o_p), 32'h21);

        bus.i_push = 1'b1; bus.i_pop = 1'b1;
        tick();
        check("pushpop_empty_depth", 32'(bus.o_depth),   32'd1);
        check("pushpop_empty_unf",   32'(bus.o_unf_err), 32'd1);

        for (int i = 0; i < 2; i++) begin
            bus.i_push = 1'b1;
            tick();
        end
        check("pre_reset_depth", 32'(bus.o_depth), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_depth", 32'(bus.o_depth), 32'd0);
        check("async_reset_p",     32'(bus.o_p),     32'h20);
        check("async_reset_empty", 32'(bus.o_empty), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 400; n++) begin
            bus.i_db      = 8'($urandom);
            bus.i_db_we   = 8'($urandom) & 8'($urandom);
            bus.i_set     = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.i_clr     = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.i_acr     = 1'($urandom);
            bus.i_acr_c   = ($urandom_range(0, 3) == 0);
            bus.i_avr     = 1'($urandom);
            bus.i_avr_v   = ($urandom_range(0, 3) == 0);
            bus.i_dbz_z   = ($urandom_range(0, 3) == 0);
            bus.i_dbn_n   = ($urandom_range(0, 3) == 0);
            bus.i_push    = ($urandom_range(0, 9) < 4);
            bus.i_pop     = ($urandom_range(0, 9) < 3);
            bus.i_err_clr = ($urandom_range(0, 9) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
